// File: rtl/keypad_entry_ctrl.sv
// Operand-entry controller: builds two BCD operands from keypad events,
// hands them to the BCD arithmetic unit over valid/ready, waits for the
// result (with timeout) and selects what the 7-segment driver shows.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_A     | entering operand A, display shows A
// S_B     | entering operand B, display shows B
// S_ISSUE | operands offered (op_valid=1), keys ignored, display busy
// S_WAIT  | waiting for res_valid or timeout, keys ignored, display busy
// S_SHOW  | result (or 0 after timeout) shown; digit/CLEAR starts over
module keypad_entry_ctrl #(
  parameter int DIGITS      = 3,
  parameter int TIMEOUT_CYC = 2_700_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    key_code,
  input  logic                          key_pulse,
  output logic [4*DIGITS-1:0]           op_a,
  output logic [4*DIGITS-1:0]           op_b,
  output logic                          op_valid,
  input  logic                          op_ready,
  input  logic [4*(DIGITS+1)-1:0]       res_bcd,
  input  logic                          res_valid,
  output logic [4*(DIGITS+1)-1:0]       disp_bcd,
  output logic [1:0]                    disp_mode,
  output logic [$clog2(DIGITS+1)-1:0]   digit_cnt,
  output logic                          err
);

  localparam int OPW = 4 * DIGITS;
  localparam int RSW = 4 * (DIGITS + 1);
  localparam int CW  = $clog2(DIGITS + 1);
  localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(DIGITS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);

  localparam logic [3:0] KEY_9     = 4'h9;
  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BS    = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  localparam logic [1:0] MODE_A    = 2'd0;
  localparam logic [1:0] MODE_B    = 2'd1;
  localparam logic [1:0] MODE_BUSY = 2'd2;
  localparam logic [1:0] MODE_RES  = 2'd3;

  typedef enum logic [2:0] {
    S_A     = 3'd0,
    S_B     = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_SHOW  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [OPW-1:0]  a_q, a_d;
  logic [OPW-1:0]  b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [RSW-1:0]  res_q, res_d;
  logic            op_valid_q, op_valid_d;
  logic [1:0]      disp_mode_q, disp_mode_d;
  logic [RSW-1:0]  disp_bcd_q, disp_bcd_d;

  logic [OPW-1:0]  edit_src;
  logic [OPW-1:0]  edit_val;
  logic [CW-1:0]   edit_cnt;
  logic            is_digit;

  assign is_digit = (key_code <= KEY_9);

  // Digit/backspace edit of whichever operand is currently being entered.
  always_comb begin
    edit_src = (state_q == S_B) ? b_q : a_q;
    edit_val = edit_src;
    edit_cnt = cnt_q;
    if (is_digit) begin
      if (cnt_q < CNT_MAX) begin
        edit_val = {edit_src[OPW-5:0], key_code};
        edit_cnt = cnt_q + CNT_ONE;
      end
    end else if (key_code == KEY_BS) begin
      if (cnt_q != '0) begin
        edit_val = edit_src >> 4;
        edit_cnt = cnt_q - CNT_ONE;
      end
    end
  end

  // Next-state and next-register values; display outputs follow the next state.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    res_d   = res_q;

    case (state_q)
      S_A, S_B: begin
        if (key_pulse) begin
          if (key_code == KEY_ENTER) begin
            if (state_q == S_A) begin
              state_d = S_B;
              cnt_d   = '0;
              b_d     = '0;
            end else begin
              state_d = S_ISSUE;
            end
          end else if (key_code == KEY_CLEAR) begin
            state_d = S_A;
            cnt_d   = '0;
            a_d     = '0;
            b_d     = '0;
          end else begin
            cnt_d = edit_cnt;
            if (state_q == S_A) a_d = edit_val;
            else                b_d = edit_val;
          end
        end
      end
      S_ISSUE: begin
        if (op_ready) begin
          state_d = S_WAIT;
          tmo_d   = TMO_LOAD;
        end
      end
      S_WAIT: begin
        // A result in the same cycle as a key wins; the key is simply dropped.
        if (res_valid) begin
          res_d   = res_bcd;
          err_d   = 1'b0;
          state_d = S_SHOW;
        end else if (tmo_q == '0) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_SHOW;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      S_SHOW: begin
        if (key_pulse) begin
          if (is_digit) begin
            a_d     = OPW'(key_code);
            b_d     = '0;
            cnt_d   = CNT_ONE;
            err_d   = 1'b0;
            state_d = S_A;
          end else if (key_code == KEY_CLEAR) begin
            a_d     = '0;
            b_d     = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = S_A;
          end
        end
      end
      default: state_d = S_A;
    endcase

    op_valid_d  = (state_d == S_ISSUE);
    disp_mode_d = MODE_BUSY;
    disp_bcd_d  = '0;
    case (state_d)
      S_A: begin
        disp_mode_d = MODE_A;
        disp_bcd_d  = {4'h0, a_d};
      end
      S_B: begin
        disp_mode_d = MODE_B;
        disp_bcd_d  = {4'h0, b_d};
      end
      S_SHOW: begin
        disp_mode_d = MODE_RES;
        disp_bcd_d  = res_d;
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_A;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
      res_q       <= '0;
      op_valid_q  <= 1'b0;
      disp_mode_q <= MODE_A;
      disp_bcd_q  <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      res_q       <= res_d;
      op_valid_q  <= op_valid_d;
      disp_mode_q <= disp_mode_d;
      disp_bcd_q  <= disp_bcd_d;
    end
  end

  assign op_a      = a_q;
  assign op_b      = b_q;
  assign op_valid  = op_valid_q;
  assign disp_bcd  = disp_bcd_q;
  assign disp_mode = disp_mode_q;
  assign digit_cnt = cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: operand digits kept as queues, timeout judged
// from absolute cycle numbers, outputs compared every cycle plus literal pins.
module tb_keypad_entry_ctrl;

  localparam int DIGITS = 3;
  localparam int TMO    = 16;

  localparam int M_A = 0, M_B = 1, M_ISS = 2, M_WAIT = 3, M_SHOW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_code = '0;
  logic        key_pulse = 1'b0;
  logic [11:0] op_a, op_b;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [15:0] res_bcd = '0;
  logic        res_valid = 1'b0;
  logic [15:0] disp_bcd;
  logic [1:0]  disp_mode;
  logic [1:0]  digit_cnt;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  keypad_entry_ctrl #(.DIGITS(DIGITS), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_pulse(key_pulse),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .res_bcd(res_bcd), .res_valid(res_valid), .disp_bcd(disp_bcd),
    .disp_mode(disp_mode), .digit_cnt(digit_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: digits held most-significant first.
  int mst = M_A;
  int qa[$];
  int qb[$];
  int mres = 0;
  bit merr = 1'b0;
  int cyc = 0;
  int xfer = 0;

  always @(posedge clk) begin
    if (rst) begin
      mst = M_A; qa.delete(); qb.delete(); mres = 0; merr = 1'b0;
    end else begin
      case (mst)
        M_A, M_B: if (key_pulse) begin
          if (key_code <= 4'd9) begin
            if (mst == M_A) begin
              if (qa.size() < DIGITS) qa.push_back(int'(key_code));
            end else begin
              if (qb.size() < DIGITS) qb.push_back(int'(key_code));
            end
          end else if (key_code == 4'hA) begin
            if (mst == M_A) begin mst = M_B; qb.delete(); end
            else mst = M_ISS;
          end else if (key_code == 4'hB) begin
            if (mst == M_A) begin
              if (qa.size() > 0) void'(qa.pop_back());
            end else begin
              if (qb.size() > 0) void'(qb.pop_back());
            end
          end else if (key_code == 4'hC) begin
            qa.delete(); qb.delete(); mst = M_A;
          end
        end
        M_ISS: if (op_ready) begin mst = M_WAIT; xfer = cyc; end
        M_WAIT: begin
          if (res_valid) begin
            mres = int'(res_bcd); merr = 1'b0; mst = M_SHOW;
          end else if (cyc - xfer == TMO) begin
            mres = 0; merr = 1'b1; mst = M_SHOW;
          end
        end
        M_SHOW: if (key_pulse) begin
          if (key_code <= 4'd9) begin
            qa.delete(); qa.push_back(int'(key_code)); qb.delete();
            merr = 1'b0; mst = M_A;
          end else if (key_code == 4'hC) begin
            qa.delete(); qb.delete(); merr = 1'b0; mst = M_A;
          end
        end
        default: mst = M_A;
      endcase
    end
    cyc++;
  end

  logic [31:0] ea, eb, em, ed, ec;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      ea = 0; eb = 0;
      foreach (qa[i]) ea = (ea << 4) | 32'(qa[i]);
      foreach (qb[i]) eb = (eb << 4) | 32'(qb[i]);
      case (mst)
        M_A:     begin em = 0; ed = ea; end
        M_B:     begin em = 1; ed = eb; end
        M_SHOW:  begin em = 3; ed = 32'(mres); end
        default: begin em = 2; ed = 0; end
      endcase
      ec = (mst == M_A) ? 32'(qa.size()) : 32'(qb.size());
      chk("cyc_op_a", 32'(op_a), ea);
      chk("cyc_op_b", 32'(op_b), eb);
      chk("cyc_op_valid", 32'(op_valid), 32'(mst == M_ISS));
      chk("cyc_disp_mode", 32'(disp_mode), em);
      if (em != 2) chk("cyc_disp_bcd", 32'(disp_bcd), ed);
      chk("cyc_digit_cnt", 32'(digit_cnt), ec);
      chk("cyc_err", 32'(err), 32'(merr));
    end
  end

  task automatic step(input bit kp, input logic [3:0] kc, input bit rdy,
                      input bit rv, input logic [15:0] rb, input bit r);
    key_pulse = kp; key_code = kc; op_ready = rdy;
    res_valid = rv; res_bcd = rb; rst = r;
    @(posedge clk);
    #1;
    key_pulse = 1'b0; op_ready = 1'b0; res_valid = 1'b0; rst = 1'b0;
  endtask

  task automatic key(input logic [3:0] c);
    step(1'b1, c, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  int vcnt;
  int j;

  initial begin
    step(1'b0, 4'h0, 1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk_en = 1'b1;
    chk("rst_op_a", 32'(op_a), 32'h0);
    chk("rst_op_b", 32'(op_b), 32'h0);
    chk("rst_op_valid", 32'(op_valid), 32'h0);
    chk("rst_disp_mode", 32'(disp_mode), 32'h0);
    chk("rst_disp_bcd", 32'(disp_bcd), 32'h0);
    chk("rst_digit_cnt", 32'(digit_cnt), 32'h0);
    chk("rst_err", 32'(err), 32'h0);

    // res_valid / op_ready outside their states are ignored
    step(1'b0, 4'h0, 1'b1, 1'b1, 16'h9999, 1'b0);
    chk("stray_res_mode", 32'(disp_mode), 32'h0);
    chk("stray_res_bcd", 32'(disp_bcd), 32'h0);

    key(4'h1); key(4'h2); key(4'h3);
    chk("a123_op_a", 32'(op_a), 32'h123);
    chk("a123_cnt", 32'(digit_cnt), 32'd3);
    chk("a123_disp", 32'(disp_bcd), 32'h0123);
    key(4'h4);
    chk("sat_op_a", 32'(op_a), 32'h123);
    chk("sat_cnt", 32'(digit_cnt), 32'd3);
    key(4'hE);
    chk("ignored_E", 32'(op_a), 32'h123);

    key(4'hC);
    key(4'h4); key(4'h5); key(4'hB); key(4'h7);
    chk("bs_op_a", 32'(op_a), 32'h047);
    chk("bs_cnt", 32'(digit_cnt), 32'd2);
    key(4'hC);
    chk("clr_op_a", 32'(op_a), 32'h0);
    chk("clr_cnt", 32'(digit_cnt), 32'd0);
    chk("clr_mode", 32'(disp_mode), 32'd0);
    key(4'hB);
    chk("bs_empty_cnt", 32'(digit_cnt), 32'd0);

    key(4'h1); key(4'h2); key(4'h3); key(4'hA);
    chk("enter_mode_b", 32'(disp_mode), 32'd1);
    chk("enter_cnt0", 32'(digit_cnt), 32'd0);
    key(4'h4); key(4'h5); key(4'h6);
    chk("b456_op_b", 32'(op_b), 32'h456);
    chk("b456_disp", 32'(disp_bcd), 32'h0456);
    key(4'hA);
    vcnt = int'(op_valid);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'h7, 1'b0, 1'b0, 16'h0, 1'b0);
      vcnt += int'(op_valid);
      chk("issue_hold_a", 32'(op_a), 32'h123);
      chk("issue_hold_b", 32'(op_b), 32'h456);
    end
    step(1'b0, 4'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    vcnt += int'(op_valid);
    chk("valid_cycles", 32'(vcnt), 32'd6);
    chk("wait_mode", 32'(disp_mode), 32'd2);

    idle(); idle();
    step(1'b0, 4'h0, 1'b0, 1'b1, 16'h0579, 1'b0);
    chk("res_mode", 32'(disp_mode), 32'd3);
    chk("res_disp", 32'(disp_bcd), 32'h0579);
    key(4'hA);
    chk("show_enter_ign", 32'(disp_mode), 32'd3);
    key(4'h8);
    chk("new_mode", 32'(disp_mode), 32'd0);
    chk("new_op_a", 32'(op_a), 32'h008);
    chk("new_cnt", 32'(digit_cnt), 32'd1);

    // timeout path
    key(4'hA); key(4'h2); key(4'hA);
    step(1'b0, 4'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    j = 0;
    while (err !== 1'b1 && j < 40) begin
      idle();
      j++;
    end
    chk("timeout_cycles", 32'(j), 32'd16);
    chk("timeout_disp", 32'(disp_bcd), 32'h0);
    chk("timeout_mode", 32'(disp_mode), 32'd3);
    key(4'hC);
    chk("timeout_clr_err", 32'(err), 32'd0);
    chk("timeout_clr_mode", 32'(disp_mode), 32'd0);

    // result and key in the same cycle while waiting
    key(4'h9); key(4'hA); key(4'h1); key(4'hA);
    step(1'b0, 4'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    idle(); idle(); idle();
    step(1'b1, 4'h5, 1'b0, 1'b1, 16'h1234, 1'b0);
    chk("race_mode", 32'(disp_mode), 32'd3);
    chk("race_disp", 32'(disp_bcd), 32'h1234);
    chk("race_op_a", 32'(op_a), 32'h009);

    // reset while operands are offered
    key(4'h3); key(4'hA); key(4'hA);
    chk("pre_rst_valid", 32'(op_valid), 32'd1);
    step(1'b0, 4'h0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("mid_rst_valid", 32'(op_valid), 32'd0);
    chk("mid_rst_op_a", 32'(op_a), 32'h0);
    chk("mid_rst_mode", 32'(disp_mode), 32'd0);
    chk("mid_rst_disp", 32'(disp_bcd), 32'h0);
    chk("mid_rst_cnt", 32'(digit_cnt), 32'd0);
    idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Operand-entry controller between the keypad scanner (`module_lecture`) and the BCD arithmetic unit. It consumes one-cycle `key_pulse`/`key_code` events and builds two decimal operands, A and B, digit by digit. It issues the operands to the arithmetic unit over a valid/ready handshake, waits for the result and holds it for display. It also drives the display-source selection for the 7-segment driver.

## Interface
Parameters:
- `DIGITS`, default 3: maximum decimal digits per operand.
- `TIMEOUT_CYC`, default 2_700_000: maximum cycles to wait for a result (100 ms at 27 MHz).

Ports:
- `clk`  in  1  system clock, 27 MHz.
- `rst`  in  1  synchronous, active-high reset; one clock; sampled on rising edge of `clk`.
- `key_code`  in  4  code of pressed key; valid only in the cycle `key_pulse`=1.
- `key_pulse`  in  1  one-cycle strobe per debounced key press.
- `op_a`  out  4*DIGITS  operand A, packed BCD, least significant digit in bits [3:0].
- `op_b`  out  4*DIGITS  operand B, packed BCD.
- `op_valid`  out  1  operands offered to the arithmetic unit.
- `op_ready`  in  1  arithmetic unit accepts operands.
- `res_bcd`  in  4*(DIGITS+1)  result, packed BCD.
- `res_valid`  in  1  one-cycle result strobe.
- `disp_bcd`  out  4*(DIGITS+1)  value to display.
- `disp_mode`  out  2  0=A, 1=B, 2=busy, 3=result.
- `digit_cnt`  out  2+  digits entered for the current operand; width $clog2(DIGITS+1).
- `err`  out  1  result timeout flag.

## Operation
Key map:
- 0x0–0x9 = digit.
- 0xA = ENTER.
- 0xB = BACKSPACE.
- 0xC = CLEAR.
- 0xD–0xF are ignored in every state.

States:
- **S_A**: entering A; `disp_mode`=0; `disp_bcd`={0,A}.
  - Digit: if `digit_cnt`<DIGITS, A <= {A[4*DIGITS-5:0], d} and cnt+1. Otherwise the digit is ignored (saturate, no wrap).
  - Leading zeros count as digits.
  - BACKSPACE: if cnt>0, A <= A>>4 and cnt−1. Otherwise no change.
  - ENTER: go to S_B and set cnt=0; B=0. An empty A is a legal value of 0.
- **S_B**: identical entry rules applied to B; `disp_mode`=1; `disp_bcd`={0,B}.
  - ENTER: go to S_ISSUE.
- **S_ISSUE**: `op_valid`=1; `disp_mode`=2.
  - `op_a`/`op_b` are held stable while `op_valid`=1.
  - Transfer occurs in the cycle `op_valid`&&`op_ready`; go to S_WAIT. Timeout counter is cleared.
  - All keys are ignored, including CLEAR.
- **S_WAIT**: `op_valid`=0; `disp_mode`=2; the timeout counter increments each cycle.
  - `res_valid`: capture `res_bcd` into the result register; clear `err`; go to S_SHOW.
  - Counter reaching TIMEOUT_CYC−1 without `res_valid`: set `err`=1; result register = 0; go to S_SHOW.
  - Keys are ignored.
- **S_SHOW**: `disp_mode`=3; `disp_bcd`=result register.
  - Digit d: clear A and B; A=d; cnt=1; clear `err`; go to S_A.
  - CLEAR: A=B=0; cnt=0; clear `err`; go to S_A.
  - ENTER and BACKSPACE are ignored.
- **CLEAR in S_A or S_B**: A=B=0; cnt=0; go to S_A.

Rules:
- `res_valid` is ignored outside S_WAIT.
- `res_valid` in the same cycle as `key_pulse` in S_WAIT: the result is captured and the key is dropped.
- `op_ready` is ignored outside S_ISSUE.

## Timing
- All outputs are registered.
- Reset values: state S_A, `op_a`=`op_b`=0, `op_valid`=0, `disp_bcd`=0, `disp_mode`=0, `digit_cnt`=0, `err`=0, timeout counter 0, result register 0.
- Reset asserted mid-operation, including in S_ISSUE with `op_valid`=1, returns everything to reset values at the next edge. A handshake in progress is abandoned.
- Key latency: `key_pulse` sampled at edge n → updated `op_a`/`op_b`/`disp_bcd`/`digit_cnt`/state visible after edge n (one cycle).
- ENTER in S_B at edge n → `op_valid`=1 from edge n.
- `op_ready` sampled at edge m with `op_valid`=1 → `op_valid`=0 after edge m.
- `op_ready` already high when `op_valid` rises gives a one-cycle transfer.
- `res_valid` at edge k → `disp_mode`=3 and `disp_bcd`=`res_bcd` after edge k.
- Timeout: `err`=1 exactly TIMEOUT_CYC cycles after the transfer edge.
- Consecutive `key_pulse` on back-to-back cycles are each processed.

## Test plan
- Reset, then keys 1,2,3 → `op_a`=0x123, `digit_cnt`=3, `disp_mode`=0; then key 4 → `op_a` stays 0x123.
- Keys 4,5, BACKSPACE, 7 → `op_a`=0x047, `digit_cnt`=2; CLEAR → `op_a`=0, `digit_cnt`=0, state S_A.
- A=0x123, ENTER, B=0x456, ENTER with `op_ready` low for 5 cycles, then high → `op_valid` high exactly 6 cycles with `op_a`=0x123 and `op_b`=0x456 stable; `disp_mode`=2.
- After transfer, `res_valid` with `res_bcd`=0x0579 → next cycle `disp_mode`=3, `disp_bcd`=0x0579; then key 8 → `disp_mode`=0, `op_a`=0x008, `digit_cnt`=1.
- TIMEOUT_CYC=16, no `res_valid` after transfer → `err`=1 at cycle 16, `disp_bcd`=0, `disp_mode`=3; CLEAR → `err`=0.
- Keys pressed and `res_valid` in the same cycle in S_WAIT → result captured, key dropped. Assert `rst` while `op_valid`=1 → all outputs 0 next cycle.
